// File: rtl/ureg_pkg.sv
// Shared definitions for the universal register: operation-select width and mode encodings.
package ureg_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_INC  = 3'b100,
        MODE_DEC  = 3'b101,
        MODE_CPL  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

endpackage

// File: rtl/ureg_bit.sv
// Single register bit with synchronous reset value and per-bit set/clear override (clear wins).
module ureg_bit (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_rst_val,
    input  logic i_d,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_q <= i_rst_val;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_set) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ureg.sv
// Parametrised universal register: hold/load/shift/inc/dec/complement with per-bit set/clear,
// registered carry/shift-out flag and combinational zero flag.
module ureg
    import ureg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin,
    input  logic [WIDTH-1:0]  set,
    input  logic [WIDTH-1:0]  clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  nq,
    output logic              co,
    output logic              zero
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_co_next;
    logic             r_co;

    assign w_inc = {1'b0, w_q} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec = w_q - {{(WIDTH-1){1'b0}}, 1'b1};

    // co is derived from the pre-edge q only; set/clr act later inside each bit cell.
    always_comb begin
        w_next    = w_q;
        w_co_next = r_co;
        case (mode_e'(mode))
            MODE_LOAD: w_next = d;
            MODE_SHL: begin
                w_next    = {w_q[WIDTH-2:0], sin};
                w_co_next = w_q[WIDTH-1];
            end
            MODE_SHR: begin
                w_next    = {sin, w_q[WIDTH-1:1]};
                w_co_next = w_q[0];
            end
            MODE_INC: begin
                w_next    = w_inc[WIDTH-1:0];
                w_co_next = w_inc[WIDTH];
            end
            MODE_DEC: begin
                w_next    = w_dec;
                w_co_next = (w_q == '0);
            end
            MODE_CPL: w_next = ~w_q;
            default: begin
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            ureg_bit u_bit (
                .i_clk     (clk),
                .i_nrst    (nrst),
                .i_rst_val (RESET_VAL[gi]),
                .i_d       (w_next[gi]),
                .i_set     (set[gi]),
                .i_clr     (clr[gi]),
                .o_q       (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_co <= 1'b0;
        end else begin
            r_co <= w_co_next;
        end
    end

    assign q    = w_q;
    assign nq   = ~w_q;
    assign co   = r_co;
    assign zero = (w_q == '0);

endmodule

// File: tb/tb_ureg.sv
// Self-checking bench for ureg: directed scenarios plus randomized traffic against an arithmetic model.
module tb_ureg;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] RV = 8'hA5;

    logic             clk;
    logic             nrst;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             co;
    logic             zero;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference state held as plain integers.
    int unsigned m_q;
    int unsigned m_co;

    ureg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .mode (mode),
        .d    (d),
        .sin  (sin),
        .set  (set),
        .clr  (clr),
        .q    (q),
        .nq   (nq),
        .co   (co),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic n, input logic [2:0] m, input int unsigned dd,
                              input logic s, input int unsigned st, input int unsigned cl);
        int unsigned res;
        int unsigned top;
        if (!n) begin
            m_q  = RV;
            m_co = 0;
            return;
        end
        res = m_q;
        top = m_q / 128;
        case (m)
            3'd1: res = dd;
            3'd2: begin res = (m_q * 2 + s) % 256; m_co = top; end
            3'd3: begin res = m_q / 2 + s * 128; m_co = m_q % 2; end
            3'd4: begin res = (m_q + 1) % 256; m_co = (m_q == 255) ? 1 : 0; end
            3'd5: begin res = (m_q + 255) % 256; m_co = (m_q == 0) ? 1 : 0; end
            3'd6: res = 255 - m_q;
            default: res = m_q;
        endcase
        m_q = (res | st) & (~cl & 32'hFF);
    endtask

    task automatic cyc(input logic n, input logic [2:0] m, input logic [7:0] dd,
                       input logic s, input logic [7:0] st, input logic [7:0] cl);
        nrst = n; mode = m; d = dd; sin = s; set = st; clr = cl;
        model_step(n, m, dd, s, st, cl);
        @(posedge clk);
        #1;
        check("model_q", q, m_q);
        check("model_nq", nq, m_q ^ 32'hFF);
        check("model_co", co, m_co);
        check("model_zero", zero, (m_q == 0) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] q_hold;
        logic       co_hold;
        logic       rn;
        logic [7:0] rs;
        logic [7:0] rc;
        n_checks = 0;
        n_errors = 0;
        m_q = 0;
        m_co = 0;
        nrst = 1'b0; mode = 3'd0; d = '0; sin = 1'b0; set = '0; clr = '0;

        // Reset beats a concurrent LOAD
        cyc(1'b0, 3'd1, 8'hFF, 1'b0, 8'h00, 8'h00);
        check("rst_q", q, 8'hA5);
        check("rst_nq", nq, 8'h5A);
        check("rst_co", co, 0);
        check("rst_zero", zero, 0);

        // INC wrap and DEC borrow
        cyc(1'b1, 3'd1, 8'hFE, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
        check("inc1_q", q, 8'hFF);
        check("inc1_co", co, 0);
        cyc(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
        check("inc2_q", q, 8'h00);
        check("inc2_co", co, 1);
        check("inc2_zero", zero, 1);
        cyc(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00);
        check("dec1_q", q, 8'hFF);
        check("dec1_co", co, 1);
        cyc(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00);
        check("dec2_q", q, 8'hFE);
        check("dec2_co", co, 0);

        // Shifts
        cyc(1'b1, 3'd1, 8'h81, 1'b1, 8'h00, 8'h00);
        cyc(1'b1, 3'd2, 8'h55, 1'b0, 8'h00, 8'h00);
        check("shl_q", q, 8'h02);
        check("shl_co", co, 1);
        cyc(1'b1, 3'd3, 8'h55, 1'b1, 8'h00, 8'h00);
        check("shr_q", q, 8'h81);
        check("shr_co", co, 0);

        // Per-bit override, clear beats set
        cyc(1'b1, 3'd1, 8'h0F, 1'b0, 8'hF0, 8'h01);
        check("setclr_q", q, 8'hFE);
        cyc(1'b1, 3'd1, 8'h0F, 1'b0, 8'h01, 8'h01);
        check("clrwin_bit0", q[0], 0);
        check("clrwin_q", q, 8'h0E);

        // HOLD stability, CPL, reserved
        cyc(1'b1, 3'd2, 8'h00, 1'b1, 8'h00, 8'h00);
        q_hold = q;
        co_hold = co;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'd0, 8'hAA, 1'b1, 8'h00, 8'h00);
            check("hold_q", q, q_hold);
            check("hold_co", co, co_hold);
        end
        cyc(1'b1, 3'd1, 8'h3C, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00);
        check("cpl_q", q, 8'hC3);
        cyc(1'b1, 3'd7, 8'h11, 1'b1, 8'h00, 8'h00);
        check("rsvd_q", q, 8'hC3);

        // Reset mid-count
        cyc(1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
        check("count5_q", q, 8'h05);
        cyc(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
        check("midrst_q", q, 8'hA5);
        check("midrst_co", co, 0);
        cyc(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
        check("resume_q", q, 8'hA6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 19) != 0);
            rs = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc(rn, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), rs, rc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
